// File: rtl/wired_ex_div_iter.sv
// wired_ex_div_iter: iterative radix-2 restoring divider (signed/unsigned, quotient/remainder) with valid/ready handshakes, flush and early-out; ports clk, rst, flush_i, valid_i/ready_o/op_i/a_i/b_i/tag_i request side, valid_o/ready_i/result_o/tag_o result side, busy_o
module wired_ex_div_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6,
  parameter int EARLY_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state;
  logic rem_sel, neg_q, neg_r;
  logic [WIDTH-1:0] dvs, quo, rem, cnt;
  logic a_neg, b_neg, div0, ovf, early, special, accept, fits;
  logic [WIDTH-1:0] a_abs, b_abs, sp_res, q_fix, r_fix;
  logic [WIDTH:0] trial;
  assign a_neg = !op_i[0] && a_i[WIDTH-1];
  assign b_neg = !op_i[0] && b_i[WIDTH-1];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;
  assign div0 = b_i == '0;
  assign ovf = !op_i[0] && a_i == MIN && b_i == '1;
  assign early = EARLY_OUT != 0 && a_abs < b_abs;
  assign special = div0 || ovf || early;
  // Remainder of every special case is the dividend itself, except the overflow case.
  assign sp_res = op_i[1] ? (ovf && !div0 ? '0 : a_i) : (div0 ? '1 : ovf ? MIN : '0);
  assign ready_o = !flush_i && (state == IDLE || (state == DONE && ready_i));
  assign accept = valid_i && ready_o;
  assign busy_o = state == CALC || state == FIX;
  // Shift the next dividend bit into the partial remainder and subtract the divisor if it fits.
  assign trial = {rem, quo[WIDTH-1]};
  assign fits = trial >= {1'b0, dvs};
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid_o <= 1'b0;
      result_o <= '0;
      tag_o <= '0;
      cnt <= '0;
      rem_sel <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dvs <= '0;
      quo <= '0;
      rem <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      valid_o <= 1'b0;
    end else if (accept) begin
      rem_sel <= op_i[1];
      tag_o <= tag_i;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      dvs <= b_abs;
      quo <= a_abs;
      rem <= '0;
      cnt <= WIDTH'(WIDTH);
      state <= special ? DONE : CALC;
      valid_o <= special;
      if (special) result_o <= sp_res;
    end else begin
      case (state)
        CALC: begin
          rem <= fits ? trial[WIDTH-1:0] - dvs : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= cnt - 1'b1;
          if (cnt == WIDTH'(1)) state <= FIX;
        end
        FIX: begin
          result_o <= rem_sel ? r_fix : q_fix;
          valid_o <= 1'b1;
          state <= DONE;
        end
        DONE: if (ready_i) begin
          state <= IDLE;
          valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wired_ex_div_iter.sv
// tb_wired_ex_div_iter: directed table and corner sequences at WIDTH=32, randomized back-to-back traffic at WIDTH=8 for both early-out settings
module tb_wired_ex_div_iter;
  logic clk = 0, rst = 0, flush_i = 0, valid_i = 0, ready_i = 0;
  logic ready_o, valid_o, busy_o;
  logic [1:0] op_i = 0;
  logic [31:0] a_i = 0, b_i = 0, result_o;
  logic [5:0] tag_i = 0, tag_o;
  int errs = 0, chks = 0;
  always #5 clk = ~clk;
  wired_ex_div_iter dut (.clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o));
  logic fl8 = 0;
  logic vi8 [2], rdy8 [2], ri8 [2], vo8 [2], bz8 [2];
  logic [1:0] op8 [2];
  logic [7:0] a8 [2], b8 [2], res8 [2];
  logic [5:0] tg8 [2], to8 [2];
  for (genvar g = 0; g < 2; g++) begin : g8
    wired_ex_div_iter #(.WIDTH(8), .TAG_W(6), .EARLY_OUT(g)) u (.clk(clk), .rst(rst), .flush_i(fl8),
      .valid_i(vi8[g]), .ready_o(rdy8[g]), .op_i(op8[g]), .a_i(a8[g]), .b_i(b8[g]), .tag_i(tg8[g]),
      .valid_o(vo8[g]), .ready_i(ri8[g]), .result_o(res8[g]), .tag_o(to8[g]), .busy_o(bz8[g]));
  end
  typedef struct { logic [31:0] a, b; logic [1:0] op; logic [31:0] exp; int lat; } vec_t;
  vec_t tbl [17];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int sa, sb, q, r;
    sa = op[0] ? int'(a) : int'($signed(a));
    sb = op[0] ? int'(b) : int'($signed(b));
    if (sb == 0) begin q = -1; r = sa; end
    else if (!op[0] && sa == -128 && sb == -1) begin q = -128; r = 0; end
    else begin q = sa / sb; r = sa % sb; end
    return op[1] ? r[7:0] : q[7:0];
  endfunction
  function automatic bit spec8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input int eo);
    int sa, sb;
    sa = op[0] ? int'(a) : int'($signed(a));
    sb = op[0] ? int'(b) : int'($signed(b));
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    return b == 0 || (!op[0] && a == 8'h80 && b == 8'hff) || (eo != 0 && sa < sb);
  endfunction
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic [5:0] tg,
                       output logic [31:0] res, output logic [5:0] tgo, output int lat);
    int n;
    valid_i = 1; a_i = a; b_i = b; op_i = op; tag_i = tg; ready_i = 1; n = 0;
    #1;
    while (!ready_o && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    valid_i = 0; lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    res = result_o; tgo = tag_o;
    @(posedge clk); #1;
  endtask
  task automatic watch_quiet(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin @(posedge clk); #1; if (valid_o) seen++; end
    chk(nm, seen, 0);
  endtask
  initial begin
    logic [31:0] res;
    logic [5:0] tgo;
    int lat, cyc;
    int issued [2], done_ops [2], pend [2], seen [2], exp_t [2];
    logic acc [2];
    logic [7:0] exp_r [2];
    logic [5:0] exp_g [2];
    tbl = '{
      '{32'hFFFFFFF9, 32'd2, 2'b00, 32'hFFFFFFFD, 34}, '{32'hFFFFFFF9, 32'd2, 2'b10, 32'hFFFFFFFF, 34},
      '{32'hFFFFFFFF, 32'h10, 2'b01, 32'h0FFFFFFF, 34}, '{32'hFFFFFFFF, 32'h0, 2'b01, 32'hFFFFFFFF, 1},
      '{32'h80000000, 32'hFFFFFFFF, 2'b00, 32'h80000000, 1}, '{32'h80000000, 32'hFFFFFFFF, 2'b10, 32'h0, 1},
      '{32'd3, 32'd10, 2'b00, 32'h0, 1}, '{32'hFFFFFFFD, 32'd10, 2'b10, 32'hFFFFFFFD, 1},
      '{32'd100, 32'hFFFFFFF9, 2'b00, 32'hFFFFFFF2, 34}, '{32'd100, 32'hFFFFFFF9, 2'b10, 32'd2, 34},
      '{32'hFFFFFF9C, 32'hFFFFFFF9, 2'b00, 32'd14, 34}, '{32'hFFFFFF9C, 32'hFFFFFFF9, 2'b10, 32'hFFFFFFFE, 34},
      '{32'h80000000, 32'd3, 2'b01, 32'h2AAAAAAA, 34}, '{32'h80000000, 32'd3, 2'b11, 32'd2, 34},
      '{32'hFFFFFFFB, 32'h0, 2'b10, 32'hFFFFFFFB, 1}, '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'd1, 34},
      '{32'd5, 32'hFFFFFFFE, 2'b11, 32'd5, 1}};
    for (int k = 0; k < 2; k++) begin
      vi8[k] = 0; ri8[k] = 0; op8[k] = 0; a8[k] = 0; b8[k] = 0; tg8[k] = 0;
      issued[k] = 0; done_ops[k] = 0; pend[k] = 0; seen[k] = 0; exp_t[k] = 0; acc[k] = 0;
      exp_r[k] = 0; exp_g[k] = 0;
    end
    #2 rst = 1;
    #2;
    chk("rst valid_o", valid_o, 0); chk("rst busy_o", busy_o, 0); chk("rst ready_o", ready_o, 1);
    chk("rst result_o", result_o, 0); chk("rst tag_o", tag_o, 0);
    flush_i = 1; #1;
    chk("rst ready_o flush", ready_o, 0);
    flush_i = 0;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      run32(tbl[i].a, tbl[i].b, tbl[i].op, 6'(i + 1), res, tgo, lat);
      chk($sformatf("tbl%0d result", i), res, tbl[i].exp);
      chk($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d tag", i), tgo, 6'(i + 1));
      chk($sformatf("tbl%0d idle", i), valid_o, 0);
    end
    valid_i = 1; a_i = 32'hFFFFFFF9; b_i = 2; op_i = 2'b00; tag_i = 5; ready_i = 0;
    @(posedge clk); #1 valid_i = 0;
    lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("hold latency", lat, 34);
    for (int i = 0; i < 5; i++) begin
      chk("hold valid", valid_o, 1); chk("hold result", result_o, 32'hFFFFFFFD); chk("hold tag", tag_o, 5);
      chk("hold ready_o low", ready_o, 0);
      @(posedge clk); #1;
    end
    valid_i = 1; a_i = 100; b_i = 32'hFFFFFFF9; op_i = 2'b00; tag_i = 9; ready_i = 1;
    #1 chk("handoff ready_o", ready_o, 1);
    @(posedge clk); #1 valid_i = 0;
    chk("handoff valid drop", valid_o, 0); chk("handoff busy", busy_o, 1);
    lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("handoff latency", lat, 34); chk("handoff result", result_o, 32'hFFFFFFF2); chk("handoff tag", tag_o, 9);
    valid_i = 1; a_i = 5; b_i = 0; op_i = 2'b01; tag_i = 12;
    @(posedge clk); #1 valid_i = 0;
    chk("b2b special valid", valid_o, 1); chk("b2b special result", result_o, 32'hFFFFFFFF);
    chk("b2b special tag", tag_o, 12);
    @(posedge clk); #1;
    chk("b2b special done", valid_o, 0);
    valid_i = 1; a_i = 32'hFFFFFFF9; b_i = 2; op_i = 2'b00; tag_i = 11;
    @(posedge clk); #1 valid_i = 0;
    repeat (10) @(posedge clk);
    #1 flush_i = 1; valid_i = 1; a_i = 7; b_i = 0; tag_i = 13;
    #1 chk("flush ready_o", ready_o, 0);
    @(posedge clk); #1 flush_i = 0; valid_i = 0;
    chk("flush busy", busy_o, 0); chk("flush valid", valid_o, 0);
    watch_quiet("flush no result", 40);
    run32(100, 32'hFFFFFFF9, 2'b10, 14, res, tgo, lat);
    chk("post flush result", res, 2); chk("post flush latency", lat, 34); chk("post flush tag", tgo, 14);
    valid_i = 1; a_i = 1000; b_i = 3; op_i = 2'b01; tag_i = 15;
    @(posedge clk); #1 valid_i = 0;
    repeat (5) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("midrst busy", busy_o, 0); chk("midrst valid", valid_o, 0); chk("midrst result", result_o, 0);
    chk("midrst tag", tag_o, 0);
    @(posedge clk); #1 rst = 0;
    watch_quiet("midrst no result", 40);
    run32(1000, 3, 2'b01, 16, res, tgo, lat);
    chk("post rst result", res, 333); chk("post rst latency", lat, 34);
    for (cyc = 0; cyc < 20000 && (done_ops[0] < 200 || done_ops[1] < 200); cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) vi8[k] = 0;
        acc[k] = 0;
        if (!vi8[k] && issued[k] < 200 && $urandom_range(3) != 0) begin
          vi8[k] = 1;
          op8[k] = 2'($urandom_range(3));
          a8[k] = $urandom_range(7) == 0 ? 8'h80 : 8'($urandom);
          case ($urandom_range(7))
            0: b8[k] = 8'h00;
            1: b8[k] = 8'hFF;
            2: b8[k] = 8'($urandom_range(7));
            default: b8[k] = 8'($urandom);
          endcase
          tg8[k] = 6'($urandom);
          issued[k]++;
        end
        ri8[k] = $urandom_range(3) != 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (vo8[k] && !seen[k]) begin
          seen[k] = 1;
          if (pend[k] == 0) chk($sformatf("rnd%0d spurious valid", k), 1, 0);
          else chk($sformatf("rnd%0d latency", k), cyc, exp_t[k]);
        end
        if (vo8[k] && ri8[k]) begin
          chk($sformatf("rnd%0d result", k), res8[k], exp_r[k]);
          chk($sformatf("rnd%0d tag", k), to8[k], exp_g[k]);
          pend[k] = 0; seen[k] = 0; done_ops[k]++;
        end
        if (vi8[k] && rdy8[k]) begin
          acc[k] = 1; pend[k] = 1;
          exp_r[k] = ref8(a8[k], b8[k], op8[k]);
          exp_g[k] = tg8[k];
          exp_t[k] = cyc + (spec8(a8[k], b8[k], op8[k], k) ? 1 : 10);
        end
      end
    end
    chk("rnd eo0 completed", done_ops[0], 200);
    chk("rnd eo1 completed", done_ops[1], 200);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
